// File: rtl/serial_tx.sv
// serial_tx: framed parallel-in / serial-out transmitter.
// A word accepted over valid/ready goes onto tx as start bit (0), WIDTH data
// bits LSB-first, then stop bit (1); every bit is held CLKS_PER_BIT cycles.
// All outputs come straight from flops whose next value is derived from the
// next-state logic, so nothing on the outputs depends combinationally on the
// inputs, and clr forces the idle values onto the outputs immediately.
module serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   // bit-time counter needs at least one bit even when CLKS_PER_BIT is 1
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // bit index must be able to hold WIDTH itself
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [IW-1:0]    idx_q,   idx_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             tx_q,    tx_d;
   logic             busy_q,  busy_d;
   logic             ready_q, ready_d;
   logic             done_q,  done_d;

   // State, datapath and output registers; clr returns everything to idle at once
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         idx_q   <= IDX_ZERO;
         shreg_q <= {WIDTH{1'b0}};
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // Next-state, bit-time counter, bit index and shift register
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = CNT_ZERO;
            if (din_valid) begin
               shreg_d = din;
               idx_d   = IDX_ZERO;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               shreg_d = shreg_q >> 1'b1;
               idx_d   = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d   = CNT_ZERO;
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state
   always_comb begin
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b0;
      done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
      case (state_d)
         S_IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
         S_START: begin
            tx_d   = 1'b0;
            busy_d = 1'b1;
         end
         S_DATA: begin
            tx_d   = shreg_d[0];
            busy_d = 1'b1;
         end
         S_STOP: begin
            tx_d   = 1'b1;
            busy_d = 1'b1;
         end
         default: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign din_ready = ready_q;
   assign done      = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: two transmitters (8 bits x 4 clk/bit and 1 bit x 1 clk/bit)
// compared every cycle against a frame-position model, plus a bench-side
// receiver that recovers words from the 8-bit line and literal frame checks.
module tb_serial_tx;

   localparam int W0 = 8;
   localparam int C0 = 4;
   localparam int W1 = 1;
   localparam int C1 = 1;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] din0 = 8'h00;
   logic       v0 = 1'b0;
   logic       rdy0, tx0, busy0, done0;
   logic [0:0] din1 = 1'b0;
   logic       v1 = 1'b0;
   logic       rdy1, tx1, busy1, done1;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int done_total = 0;
   int hs_cyc = 0;

   // model: position inside the current frame (-1 = idle), latched word, done flag
   int         m_pos [2] = '{-1, -1};
   logic [7:0] m_word[2] = '{8'h00, 8'h00};
   logic       m_done[2] = '{1'b0, 1'b0};
   logic [7:0] sent_q[$];

   // receiver state
   bit         rx_act = 1'b0;
   int         rx_k = 0;
   int         rx_words = 0;
   logic [7:0] rx_word = 8'h00;

   always #5 clk = ~clk;

   serial_tx #(.WIDTH(W0), .CLKS_PER_BIT(C0)) dut0 (
      .clk(clk), .clr(clr), .din(din0), .din_valid(v0),
      .din_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
   );

   serial_tx #(.WIDTH(W1), .CLKS_PER_BIT(C1)) dut1 (
      .clk(clk), .clr(clr), .din(din1), .din_valid(v1),
      .din_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic int mw(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   function automatic int mc(input int i);
      return (i == 0) ? C0 : C1;
   endfunction

   function automatic int flen(input int i);
      return (mw(i) + 2) * mc(i);
   endfunction

   function automatic logic vin(input int i);
      return (i == 0) ? v0 : v1;
   endfunction

   function automatic logic [7:0] win(input int i);
      return (i == 0) ? din0 : {7'b0000000, din1};
   endfunction

   // line level the frame rules give for the model's current position
   function automatic logic exp_tx(input int i);
      int b;
      if (m_pos[i] < 0) return 1'b1;
      b = m_pos[i] / mc(i);
      if (b == 0) return 1'b0;
      if (b <= mw(i)) return m_word[i][b-1];
      return 1'b1;
   endfunction

   // behavioural model: advance frame position, accept a word when idle
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i]  <= -1;
            m_done[i] <= 1'b0;
         end
         sent_q.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= (m_pos[i] == flen(i) - 1);
            if (m_pos[i] >= 0) begin
               m_pos[i] <= (m_pos[i] == flen(i) - 1) ? -1 : m_pos[i] + 1;
            end else if (vin(i)) begin
               m_pos[i]  <= 0;
               m_word[i] <= win(i);
               if (i == 0) sent_q.push_back(din0);
            end
         end
      end
   end

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // per-cycle compare against the model, done counter and line receiver
   always @(negedge clk) begin
      if (chk_en) begin
         check("tx0",   tx0,   exp_tx(0));
         check("busy0", busy0, m_pos[0] >= 0);
         check("rdy0",  rdy0,  m_pos[0] < 0);
         check("done0", done0, m_done[0]);
         check("tx1",   tx1,   exp_tx(1));
         check("busy1", busy1, m_pos[1] >= 0);
         check("rdy1",  rdy1,  m_pos[1] < 0);
         check("done1", done1, m_done[1]);
      end
      if (done0 === 1'b1) done_total <= done_total + 1;
      if (clr) begin
         rx_act <= 1'b0;
         rx_k   <= 0;
      end else if (!rx_act) begin
         if (tx0 === 1'b0) begin
            rx_act <= 1'b1;
            rx_k   <= 1;
         end
      end else begin
         rx_k <= rx_k + 1;
         if (rx_k >= C0 && rx_k < (W0 + 1) * C0 && (rx_k % C0) == C0 / 2)
            rx_word[rx_k / C0 - 1] <= tx0;
         if (rx_k == (W0 + 1) * C0 + C0 / 2) begin
            rx_act <= 1'b0;
            check("rx_stop", tx0, 1'b1);
            check("rx_pending", sent_q.size() != 0, 1'b1);
            if (sent_q.size() != 0) check("rx_word", rx_word, sent_q.pop_front());
            rx_words <= rx_words + 1;
         end
      end
   end

   // offer a word on dut0 and wait (bounded) for the handshake edge
   task automatic send0(input logic [7:0] w, input bit keep_valid);
      bit got;
      got  = 1'b0;
      din0 = w;
      v0   = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = rdy0;
         @(posedge clk);
         #1;
      end
      hs_cyc = cyc;
      if (!keep_valid) v0 = 1'b0;
      check("send_handshake", got, 1'b1);
   endtask

   initial begin
      logic       cap[40];
      logic [9:0] mid;
      int         bad;
      int         d0;
      int         h1;

      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_tx", tx0, 1'b1);
      check("rst_busy", busy0, 1'b0);
      check("rst_ready", rdy0, 1'b1);
      check("rst_done", done0, 1'b0);

      // single A5 frame, literal waveform
      @(posedge clk); #1;
      d0 = done_total;
      send0(8'hA5, 1'b0);
      din0 = 8'h3C;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         cap[j] = tx0;
         if (j == 39) check("t2_done_early", done0, 1'b0);
      end
      @(negedge clk);
      check("t2_done", done0, 1'b1);
      check("t2_idle_tx", tx0, 1'b1);
      @(negedge clk);
      check("t2_done_once", done0, 1'b0);
      bad = 0;
      for (int b = 0; b < 10; b++) begin
         mid[b] = cap[b*4+2];
         for (int c = 0; c < 4; c++) if (cap[b*4+c] !== cap[b*4]) bad++;
      end
      check("t2_frame", mid, 10'b1101001010);
      check("t2_hold", bad, 0);
      check("t2_done_count", done_total - d0, 1);

      // 1-bit, 1-clk/bit frame on dut1
      @(posedge clk); #1;
      din1 = 1'b1;
      v1   = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      @(negedge clk); check("t5_c0", tx1, 1'b0);
      @(negedge clk); check("t5_c1", tx1, 1'b1);
      @(negedge clk); check("t5_c2", tx1, 1'b1); check("t5_c2_done", done1, 1'b0);
      @(negedge clk); check("t5_c3_done", done1, 1'b1);

      // back-to-back frames with valid held
      repeat (3) @(posedge clk); #1;
      d0 = done_total;
      send0(8'h00, 1'b1);
      h1 = hs_cyc;
      send0(8'hFF, 1'b0);
      check("t3_gap", hs_cyc - h1, 41);
      repeat (45) @(posedge clk); #1;
      check("t3_done_count", done_total - d0, 2);

      // din/din_valid noise during a frame
      send0(8'($urandom), 1'b0);
      for (int j = 0; j < 38; j++) begin
         din0 = 8'($urandom);
         v0   = 1'($urandom_range(1, 0));
         @(negedge clk);
         check("t4_ready_in_busy", rdy0 & busy0, 1'b0);
         @(posedge clk); #1;
      end
      v0 = 1'b0;
      repeat (10) @(posedge clk); #1;

      // clr mid-DATA
      send0(8'($urandom), 1'b0);
      repeat (12) @(posedge clk);
      #1 clr = 1'b1;
      #1;
      check("t1_tx", tx0, 1'b1);
      check("t1_busy", busy0, 1'b0);
      check("t1_ready", rdy0, 1'b1);
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
      d0 = done_total;
      repeat (50) @(posedge clk); #1;
      check("t1_no_done", done_total - d0, 0);

      // random words through the receiver
      for (int n = 0; n < 256; n++) begin
         send0(8'($urandom), ($urandom_range(3, 0) != 0) && (n != 255));
         if (!v0) repeat ($urandom_range(4, 0)) @(posedge clk);
         #1;
      end
      v0 = 1'b0;
      repeat (60) @(posedge clk); #1;
      check("drain_empty", sent_q.size(), 0);
      check("rx_words_min", rx_words >= 260, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
